// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: widths, major opcodes, encoder formats and immediate range limits.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    I_ALU  = 3'd0,
    I_LD   = 3'd1,
    I_JALR = 3'd2,
    S      = 3'd3,
    B      = 3'd4,
    LUI    = 3'd5,
    AUIPC  = 3'd6,
    J      = 3'd7
  } instr_fmt_e;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed BOFF_MIN  = -4096;
  localparam int signed BOFF_MAX  = 4094;
  localparam int signed JOFF_MIN  = -1048576;
  localparam int signed JOFF_MAX  = 1048574;

  typedef struct packed {
    instr_fmt_e      fmt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
  } enc_req_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer; inverse of imm_gen.
// Range/alignment flag exists only when RV32I_ENC_RANGE_CHECK_EN is defined.
module instr_pack
  import rv32i_pkg::*;
(
  input  instr_fmt_e              fmt_in,
  input  logic [4:0]              rd_in,
  input  logic [4:0]              rs1_in,
  input  logic [4:0]              rs2_in,
  input  logic [2:0]              funct3_in,
  input  logic signed [XLEN-1:0]  imm_in,
  output logic [ILEN-1:0]         instr_out,
  output logic                    err_out
);

  always_comb begin
    // Unknown formats fall back to the I_ALU encoding
    instr_out = {imm_in[11:0], rs1_in, funct3_in, rd_in, OPCODE_OP_IMM};
    case (fmt_in)
      I_ALU:  instr_out = {imm_in[11:0], rs1_in, funct3_in, rd_in, OPCODE_OP_IMM};
      I_LD:   instr_out = {imm_in[11:0], rs1_in, funct3_in, rd_in, OPCODE_LOAD};
      I_JALR: instr_out = {imm_in[11:0], rs1_in, funct3_in, rd_in, OPCODE_JALR};
      S:      instr_out = {imm_in[11:5], rs2_in, rs1_in, funct3_in, imm_in[4:0], OPCODE_STORE};
      B:      instr_out = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, funct3_in,
                           imm_in[4:1], imm_in[11], OPCODE_BRANCH};
      LUI:    instr_out = {imm_in[31:12], rd_in, OPCODE_LUI};
      AUIPC:  instr_out = {imm_in[31:12], rd_in, OPCODE_AUIPC};
      J:      instr_out = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, OPCODE_JAL};
      default: ;
    endcase
  end

`ifdef RV32I_ENC_RANGE_CHECK_EN
  always_comb begin
    err_out = 1'b0;
    case (fmt_in)
      I_ALU, I_LD, I_JALR, S:
        err_out = (imm_in < IMM12_MIN) || (imm_in > IMM12_MAX);
      B:
        err_out = (imm_in < BOFF_MIN) || (imm_in > BOFF_MAX) || imm_in[0];
      J:
        err_out = (imm_in < JOFF_MIN) || (imm_in > JOFF_MAX) || imm_in[0];
      LUI, AUIPC:
        err_out = |imm_in[11:0];
      default:
        err_out = 1'b1;
    endcase
  end
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: rtl/instr_enc.sv
// Two-stage valid/ready RV32I instruction encoder with saturating handshake counters.
// RV32I_ENC_RANGE_CHECK_EN enables the err_out flag and err_cnt_out counting.
module instr_enc
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  instr_fmt_e              fmt_in,
  input  logic [4:0]              rd_in,
  input  logic [4:0]              rs1_in,
  input  logic [4:0]              rs2_in,
  input  logic [2:0]              funct3_in,
  input  logic signed [XLEN-1:0]  imm_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ILEN-1:0]         instr_out,
  output logic                    err_out,
  output logic [CNT_W-1:0]        enc_cnt_out,
  output logic [CNT_W-1:0]        err_cnt_out
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic            vld_p1, vld_p2;
  enc_req_t        req_p1;
  logic [ILEN-1:0] instr_p2;
  logic            err_p2;
  logic [ILEN-1:0] pack_instr;
  logic            pack_err;
  logic            s2_load, s1_adv, accept, out_hs;

  assign s2_load  = !vld_p2 || out_ready;
  assign s1_adv   = vld_p1 && s2_load;
  assign in_ready = !flush_in && (!vld_p1 || s2_load);
  assign accept   = in_valid && in_ready;
  assign out_hs   = vld_p2 && out_ready;

  // Stage 1: raw request register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      req_p1 <= '0;
    end else begin
      if (flush_in)    vld_p1 <= 1'b0;
      else if (accept) vld_p1 <= 1'b1;
      else if (s1_adv) vld_p1 <= 1'b0;
      if (accept)
        req_p1 <= '{fmt: fmt_in, rd: rd_in, rs1: rs1_in, rs2: rs2_in,
                    funct3: funct3_in, imm: imm_in};
    end
  end

  instr_pack u_pack (
    .fmt_in    (req_p1.fmt),
    .rd_in     (req_p1.rd),
    .rs1_in    (req_p1.rs1),
    .rs2_in    (req_p1.rs2),
    .funct3_in (req_p1.funct3),
    .imm_in    (req_p1.imm),
    .instr_out (pack_instr),
    .err_out   (pack_err)
  );

  // Stage 2: packed word; held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      instr_p2 <= '0;
      err_p2   <= 1'b0;
    end else begin
      if (flush_in)     vld_p2 <= 1'b0;
      else if (s2_load) vld_p2 <= vld_p1;
      if (s1_adv) begin
        instr_p2 <= pack_instr;
        err_p2   <= pack_err;
      end
    end
  end

  assign out_valid = vld_p2;
  assign instr_out = instr_p2;
  assign err_out   = err_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         enc_cnt_out <= '0;
    else if (out_hs) enc_cnt_out <= sat_inc(enc_cnt_out);
  end

`ifdef RV32I_ENC_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   err_cnt_out <= '0;
    else if (out_hs && err_p2) err_cnt_out <= sat_inc(err_cnt_out);
  end
`else
  assign err_cnt_out = '0;
`endif

endmodule
